muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit attached to the EX stage of the 16-bit pipelined core.
- Adds MUL (low/high) and unsigned DIV/REM, which the single-cycle ALU does not provide.
- Width is generic; the core instantiates it with W=16.
- Multi-cycle with a start/busy/done handshake; the core stalls IF/ID/EX while busy=1 and flushes it on branch kill.

Parameters:
- W, 16: operand and result width in bits; legal range W >= 2.
- CW, $clog2(W+1): step-counter width; derived, never overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only when busy=0
- op  in  2  00 MUL low, 01 MUL high (unsigned), 10 DIVU quotient, 11 REMU remainder
- a  in  W  multiplicand / dividend; sampled on an accepted start
- b  in  W  multiplier / divisor; sampled on an accepted start
- flush  in  1  abort the current operation
- busy  out  1  high while the operation is iterating
- done  out  1  one-cycle pulse; result valid
- result  out  W  selected result; held until the next done
- dz  out  1  divide-by-zero flag; valid with done, held with result

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, dz=0; counter, accumulators and latched op cleared.
- Reset mid-operation: same as power-on reset; no done is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 latches a, b and op, clears count and the accumulators, and moves to BUSY.
  - dz is latched as (op[1]==1 && b==0).
- BUSY:
  - busy=1; one algorithm step per clock; count increments.
  - After step W (count==W-1 at the edge), move to DONE.
- DONE:
  - done=1 for exactly one cycle; result and dz are updated from the accumulators at entry.
  - Next edge goes to IDLE, unless start=1, which is accepted as in IDLE (back-to-back).
- Latency: start sampled at edge E0; busy=1 during cycles E0..E_W; done=1 in the cycle after E_W. That is W+1 cycles from start to done (17 for W=16), independent of op and of the data.
- Multiply:
  - Shift-add, unsigned, product 2W bits.
  - op=00 returns product[W-1:0]; op=01 returns product[2W-1:W].
- Divide:
  - Restoring, unsigned.
  - op=10 returns the quotient; op=11 returns the remainder.
- b==0 with a divide op:
  - The algorithm runs unchanged, giving quotient = all ones and remainder = a; dz=1.
  - Latency is unchanged.
- dz is 0 for multiply ops.
- start while busy=1 is ignored; no queueing and no error.
- start while done=1 is accepted.
- result and dz stay stable from done until the next done. They are not cleared on entry to IDLE or BUSY.
- flush:
  - Any state goes to IDLE on the next edge, with busy=0 and done=0.
  - result and dz keep their previous values.
  - flush takes priority over a simultaneous start: the start is dropped.
- Priority: rst > flush > start.
- Operands are sampled once: changes on a and b during BUSY have no effect.
- All state updates happen on posedge clk; outputs are driven from registers only, with no combinational path from inputs to outputs.

Test Plan:
- W=16, op=00, a=3, b=5 -> busy=1 for 17 cycles, done pulses at cycle 17, result=0x000F, dz=0; result still 0x000F 5 cycles later.
- op=00 then op=01 with a=b=0xFFFF -> result=0x0001, then result=0xFFFE.
- op=10, a=100, b=7 -> result=14; rerun with op=11 -> result=2; dz=0 both times.
- op=10, a=0x1234, b=0 -> result=0xFFFF, dz=1; op=11 -> result=0x1234, dz=1; latency 17 cycles.
- start pulsed at cycle 5 of a busy op -> ignored, single done.
- start in the done cycle -> second op accepted, done 17 cycles later.
- flush at cycle 8 (also with start=1) -> busy=0 next cycle, no done, result keeps the prior value.
- rst asserted mid-op -> all outputs 0 next cycle.
- W=8 build -> 200/9 gives result=22 (op=10) and 2 (op=11) after 9 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / divide unit for the EX stage.
// It runs shift-add multiplication or restoring division, one step per clock, behind a start/busy/done handshake.
module muldiv_unit #(
    parameter int W  = 16,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         dz
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(W);

    state_t        state;
    logic [CW-1:0] count;
    logic [1:0]    op_q;
    logic          dz_q;
    logic [W-1:0]  opnd;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    logic [W:0]    mul_sum;
    logic [W:0]    div_shift;
    logic [W:0]    div_diff;
    logic          div_ge;

    // {hi,lo} is the product/multiplier pair for MUL and the remainder/dividend-quotient pair for DIV.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        div_shift = {hi, lo[W-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = (div_shift >= {1'b0, opnd});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            dz     <= 1'b0;
            count  <= '0;
            op_q   <= 2'b00;
            dz_q   <= 1'b0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= BUSY;
                        busy  <= 1'b1;
                        count <= '0;
                        op_q  <= op;
                        dz_q  <= op[1] && (b == '0);
                        opnd  <= b;
                        hi    <= '0;
                        lo    <= a;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    count <= count + CW'(1);
                    // W steps run at counts 0..W-1; the extra cycle at count W publishes the result.
                    if (count == LAST) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= op_q[0] ? hi : lo;
                        dz     <= dz_q;
                    end else if (op_q[1]) begin
                        hi <= div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
                        lo <= {lo[W-2:0], div_ge};
                    end else begin
                        hi <= mul_sum[W:1];
                        lo <= {mul_sum[0], lo[W-1:1]};
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, randomized ops against an arithmetic model,
// handshake corner cases (busy start, back-to-back, flush, reset), and a W=8 instance.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [15:0] a, b, result;
    logic        busy, done, dz;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, result8;
    logic        busy8, done8, dz8;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .result(result), .dz(dz)
    );

    muldiv_unit #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .flush(1'b0),
        .busy(busy8), .done(done8), .result(result8), .dz(dz8)
    );

    function automatic logic [15:0] ref_result(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        p = {16'h0, x} * {16'h0, y};
        case (o)
            2'b00:   return p[15:0];
            2'b01:   return p[31:16];
            2'b10:   return (y == 16'h0) ? 16'hFFFF : x / y;
            default: return (y == 16'h0) ? x : x % y;
        endcase
    endfunction

    function automatic logic ref_dz(input logic [1:0] o, input logic [15:0] y);
        return o[1] && (y == 16'h0);
    endfunction

    // Issues one op at a negedge and waits (bounded) for done; lat counts edges after the accepting edge.
    task automatic run16(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         output int lat, output int bcyc);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
        lat = 0; bcyc = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) bcyc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, dz} !== 3'b000 || result !== 16'h0) begin
            errors++;
            $display("FAIL reset: busy/done/dz=%b result=%h, expected 000 / 0000", {busy, done, dz}, result);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed;
        logic [1:0]  ops [8] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01};
        logic [15:0] as  [8] = '{16'd3, 16'hFFFF, 16'hFFFF, 16'd100, 16'd100, 16'h1234, 16'h1234, 16'h8000};
        logic [15:0] bs  [8] = '{16'd5, 16'hFFFF, 16'hFFFF, 16'd7, 16'd7, 16'h0, 16'h0, 16'h0002};
        logic [15:0] exp_r [8] = '{16'h000F, 16'h0001, 16'hFFFE, 16'd14, 16'd2, 16'hFFFF, 16'h1234, 16'h0001};
        logic        exp_z [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat, bcyc;
        for (int i = 0; i < 8; i++) begin
            run16(ops[i], as[i], bs[i], lat, bcyc);
            vectors++;
            if (lat !== 17 || bcyc !== 17) begin
                errors++;
                $display("FAIL directed_latency[%0d]: lat=%0d busy_cycles=%0d, expected 17 17", i, lat, bcyc);
            end
            vectors++;
            if (result !== exp_r[i] || dz !== exp_z[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: result=%h dz=%b, expected %h %b", i, result, dz, exp_r[i], exp_z[i]);
            end
            if (i == 0) begin
                repeat (5) @(negedge clk);
                vectors++;
                if (result !== 16'h000F || done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL directed_hold: result=%h done=%b busy=%b, expected 000f 0 0", result, done, busy);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [15:0] x, y;
        int lat, bcyc;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom);
            x = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       y = 16'h0;
                1:       y = 16'($urandom_range(1, 15));
                default: y = 16'($urandom);
            endcase
            run16(o, x, y, lat, bcyc);
            vectors++;
            if (lat !== 17 || result !== ref_result(o, x, y) || dz !== ref_dz(o, y)) begin
                errors++;
                $display("FAIL random[%0d] op=%b a=%h b=%h: result=%h dz=%b lat=%0d, expected %h %b 17",
                         i, o, x, y, result, dz, lat, ref_result(o, x, y), ref_dz(o, y));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy;
        int dones = 0;
        start = 1'b1; op = 2'b00; a = 16'd300; b = 16'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b10; a = 16'd9; b = 16'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                dones++;
                vectors++;
                if (result !== 16'd2100) begin
                    errors++;
                    $display("FAIL busy_start_result: result=%h, expected %h", result, 16'd2100);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL busy_start_dones: dones=%0d, expected 1", dones);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcyc;
        run16(2'b01, 16'hABCD, 16'h1234, lat, bcyc);
        vectors++;
        if (result !== ref_result(2'b01, 16'hABCD, 16'h1234)) begin
            errors++;
            $display("FAIL b2b_first: result=%h, expected %h", result, ref_result(2'b01, 16'hABCD, 16'h1234));
        end
        // Issued while done=1, so the DONE state must accept it.
        run16(2'b11, 16'd1000, 16'd33, lat, bcyc);
        vectors++;
        if (lat !== 17 || result !== 16'd10 || dz !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: result=%h dz=%b lat=%0d, expected 000a 0 17", result, dz, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_flush;
        logic [15:0] prior;
        logic        prior_dz;
        int          dones = 0;
        prior = result; prior_dz = dz;
        start = 1'b1; op = 2'b00; a = 16'd11; b = 16'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 2'b10; a = 16'd50; b = 16'd5;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== prior || dz !== prior_dz) begin
            errors++;
            $display("FAIL flush_state: busy=%b done=%b result=%h dz=%b, expected 0 0 %h %b",
                     busy, done, result, dz, prior, prior_dz);
        end
        for (int i = 0; i < 25; i++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            @(negedge clk);
        end
        vectors++;
        if (dones !== 0 || result !== prior) begin
            errors++;
            $display("FAIL flush_quiet: activity_cycles=%0d result=%h, expected 0 %h", dones, result, prior);
        end
    endtask

    task automatic test_reset_mid_op;
        int dones = 0;
        start = 1'b1; op = 2'b10; a = 16'd77; b = 16'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy, done, dz} !== 3'b000 || result !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid: busy/done/dz=%b result=%h, expected 000 / 0000", {busy, done, dz}, result);
        end
        for (int i = 0; i < 25; i++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        vectors++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL rst_mid_done: dones=%0d, expected 0", dones);
        end
    endtask

    task automatic test_w8;
        logic [1:0] o8s [2] = '{2'b10, 2'b11};
        logic [7:0] exp8 [2] = '{8'd22, 8'd2};
        int lat;
        for (int i = 0; i < 2; i++) begin
            start8 = 1'b1; op8 = o8s[i]; a8 = 8'd200; b8 = 8'd9;
            @(negedge clk);
            start8 = 1'b0;
            lat = 0;
            while (done8 !== 1'b1 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            vectors++;
            if (lat !== 9 || result8 !== exp8[i] || dz8 !== 1'b0) begin
                errors++;
                $display("FAIL w8[%0d]: result=%0d dz=%b lat=%0d, expected %0d 0 9", i, result8, dz8, lat, exp8[i]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_directed;
        test_random;
        test_start_while_busy;
        test_back_to_back;
        test_flush;
        test_reset_mid_op;
        test_w8;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
